// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-to-serial converter.
package ser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/p2s_hold_buf.sv
// One-entry holding register: captures a word (and its bit order) while the shifter is busy.
module p2s_hold_buf
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_msb_first,
  output logic [WIDTH-1:0] data,
  output logic             msb_first,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data      <= '0;
      msb_first <= 1'b0;
      full      <= 1'b0;
    end else if (load) begin
      data      <= load_data;
      msb_first <= load_msb_first;
      full      <= 1'b1;
    end else if (clear) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter with per-word bit order, frame markers and a one-word holding buffer.
module parallel_to_serial
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  ser_state_t       state, state_next;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  logic             hold_full, hold_msb_first;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load, hold_clear;

  logic             accept, last, load_shift, use_hold;
  logic [WIDTH-1:0] src_data, src_rev, sh_load;
  logic             src_msb_first;

  p2s_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (hold_load),
    .clear          (hold_clear),
    .load_data      (in_data),
    .load_msb_first (in_msb_first),
    .data           (hold_data),
    .msb_first      (hold_msb_first),
    .full           (hold_full)
  );

  assign in_ready = rst_n & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign last     = (state == SHIFT) && (cnt == CW'(WIDTH-1));

  always_comb begin
    state_next = state;
    load_shift = 1'b0;
    use_hold   = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          load_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          if (hold_full) begin
            load_shift = 1'b1;
            use_hold   = 1'b1;
            hold_clear = 1'b1;
          end else if (accept) begin
            load_shift = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (accept) begin
          hold_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // LSB-first words are loaded bit-reversed so the shifter always emits its top bit.
  assign src_data      = use_hold ? hold_data : in_data;
  assign src_msb_first = use_hold ? hold_msb_first : in_msb_first;

  always_comb begin
    src_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) src_rev[i] = src_data[WIDTH-1-i];
  end

  assign sh_load = src_msb_first ? src_data : src_rev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load_shift) begin
        sh  <= sh_load;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sh  <= {sh[WIDTH-2:0], 1'b0};
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
  end

  assign ser_valid   = (state == SHIFT);
  assign serial_out  = ser_valid & sh[WIDTH-1];
  assign frame_start = ser_valid && (cnt == '0);
  assign frame_last  = last;
  assign busy        = ser_valid | hold_full;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed self-checking bench for parallel_to_serial (WIDTH = 8).
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic       in_valid;
  logic       in_ready;
  logic       serial_out;
  logic       ser_valid;
  logic       frame_start;
  logic       frame_last;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .ser_valid    (ser_valid),
    .frame_start  (frame_start),
    .frame_last   (frame_last),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks stream bits [from, to) of a len-bit MSB-first expected stream, one per cycle.
  task automatic chk_bits(input string tag, input logic [31:0] stream, input int len,
                          input int from, input int to);
    for (int i = from; i < to; i++) begin
      chk($sformatf("%s_valid[%0d]", tag, i), ser_valid, 1'b1);
      chk($sformatf("%s_bit[%0d]", tag, i), serial_out, stream[len-1-i]);
      chk($sformatf("%s_start[%0d]", tag, i), frame_start, (i % 8) == 0);
      chk($sformatf("%s_last[%0d]", tag, i), frame_last, (i % 8) == 7);
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ser_valid"}, ser_valid, 1'b0);
    chk({tag, "_serial_out"}, serial_out, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_frame_last"}, frame_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b1;
    in_valid     = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");
    chk("post_reset_in_ready", in_ready, 1'b1);

    // Single word, MSB first
    in_data = 8'hA5; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bits("single_msb", 32'hA5, 8, 0, 8);
    chk_idle("single_msb_end");
    chk("single_msb_end_ready", in_ready, 1'b1);

    // LSB first: A5 (palindrome) then 1D, whose bit 0..7 stream is 10111000
    in_data = 8'hA5; in_msb_first = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bits("lsb_a5", 32'hA5, 8, 0, 8);
    chk_idle("lsb_a5_end");
    in_data = 8'h1D; in_msb_first = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bits("lsb_1d", 32'hB8, 8, 0, 8);
    chk_idle("lsb_1d_end");

    // Back-to-back 0F, F0
    in_data = 8'h0F; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    chk("b2b_ready_first", in_ready, 1'b1);
    in_data = 8'hF0;
    chk_bits("b2b", 32'h0FF0, 16, 0, 1);
    in_valid = 1'b0;
    chk("b2b_ready_full", in_ready, 1'b0);
    chk("b2b_busy_full", busy, 1'b1);
    chk_bits("b2b", 32'h0FF0, 16, 1, 8);
    chk("b2b_ready_after_drain", in_ready, 1'b1);
    chk_bits("b2b", 32'h0FF0, 16, 8, 16);
    chk_idle("b2b_end");

    // Backpressure: three words with in_valid held
    in_data = 8'h3C; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 8'hC3;
    chk_bits("bp", 32'h3CC35A, 24, 0, 1);
    in_data = 8'h5A;
    chk("bp_ready_full", in_ready, 1'b0);
    chk_bits("bp", 32'h3CC35A, 24, 1, 8);
    chk("bp_ready_drained", in_ready, 1'b1);
    chk_bits("bp", 32'h3CC35A, 24, 8, 9);
    in_valid = 1'b0;
    chk("bp_ready_third_held", in_ready, 1'b0);
    chk_bits("bp", 32'h3CC35A, 24, 9, 24);
    chk_idle("bp_end");

    // Mid-word reset with a buffered word
    in_data = 8'hFF; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_data = 8'h00;
    chk_bits("mid", 32'hFF00, 16, 0, 1);
    in_valid = 1'b0;
    chk("mid_busy_buffered", busy, 1'b1);
    chk_bits("mid", 32'hFF00, 16, 1, 3);
    rst_n = 1'b0;
    chk("mid_ready_in_reset", in_ready, 1'b0);
    tick();
    chk_idle("mid_reset_edge");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("mid_quiet_valid[%0d]", i), ser_valid, 1'b0);
      chk($sformatf("mid_quiet_busy[%0d]", i), busy, 1'b0);
    end
    in_data = 8'h96; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_bits("mid_next", 32'h96, 8, 0, 8);
    chk_idle("mid_next_end");

    // Mixed order: 01 MSB-first then 01 LSB-first
    in_data = 8'h01; in_msb_first = 1'b1; in_valid = 1'b1;
    tick();
    in_msb_first = 1'b0;
    chk_bits("mixed", 32'h0180, 16, 0, 1);
    in_valid = 1'b0;
    chk_bits("mixed", 32'h0180, 16, 1, 16);
    chk_idle("mixed_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
